mac16_wrapper_accum_sim: RTL and testbench
==========================================

Name: mac16_wrapper_accum_sim

Overview:
Signed 16x16 multiply-accumulate block with registered inputs and a 32-bit accumulator. It is the behavioural stand-in for the iCE40 SB_MAC16 accumulate configuration used by the biquad IIR datapath. Operands are Q2.14; the product and accumulator are Q4.28. It serves one biquad tap per enabled cycle.

Parameters:
- A_W, 16, operand A width (Q2.14)
- B_W, 16, operand B width (Q2.14)
- ACC_W, 32, accumulator/result width (Q4.28); must equal A_W+B_W

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low system reset; clears all state
- mac_rst  input  1  synchronous, active-low accumulator clear
- ce  input  1  clock enable; one accumulate per cycle held high
- a_in  input  16  signed Q2.14 operand A
- b_in  input  16  signed Q2.14 operand B
- result  output  32  signed Q4.28 accumulator value, registered

Behaviour:
- Stage 1 (input registers):
  - a_reg/b_reg load a_in/b_in on rising clk when ce=1, otherwise hold.
  - ce_reg <= ce every cycle.
- Stage 2 (accumulator):
  - On rising clk with ce_reg=1: acc <= acc + sext32(a_reg*b_reg).
  - The product is a full-precision signed 32-bit value. No shifting; Q2.14 x Q2.14 gives Q4.28 directly.
  - With ce_reg=0, acc holds.
- result = acc, driven directly from the register (no combinational path from inputs).
- Latency:
  - Inputs with ce=1 sampled at edge N are reflected in result after edge N+1.
  - A single-cycle ce pulse produces exactly one accumulate.
- Back-to-back ce=1 cycles accumulate each sampled operand pair, one per cycle, fully pipelined.
- Arithmetic: two's complement; wraps modulo 2^32 on overflow (default build).
- reset=0 (asynchronous): a_reg, b_reg, ce_reg and acc are cleared to 0, so result=0 immediately and until the first enabled accumulate after release.
- mac_rst=0 at a rising edge:
  - acc <= 0 and ce_reg <= 0. a_reg/b_reg are unaffected.
  - mac_rst takes priority over a simultaneous accumulate.
  - First accumulate after release starts from 0, so result equals the product alone.
- reset has priority over mac_rst.
- Changing a_in/b_in while ce=0 has no effect on result.

Optional Feature:
- Macro: MAC16_ACC_SAT_EN.
- When defined, the accumulate saturates to 0x7FFFFFFF or 0x80000000 on signed overflow instead of wrapping.
- When undefined, the accumulate wraps modulo 2^32.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Package mac16_pkg holds:
  - constants A_W=16, B_W=16, ACC_W=32, FRAC_IN=14, FRAC_ACC=28
  - typedefs q2_14_t (logic signed [15:0]) and q4_28_t (logic signed [31:0])
- One natural sub-module, mac16_accum_core: the stage-2 multiplier plus accumulator, including the saturation option. The top level holds the input registers and the reset muxing.

Test Plan:
- Single multiply: mac_rst pulse, then 1.0 x 1.0 (0x4000, 0x4000, ce for one cycle) -> result 0x10000000 two edges later. 1.5 x 1.0 -> 0x18000000. -1.0 x 1.0 -> 0xF0000000.
- Accumulate: three ce pulses of 1.0 x 1.0 -> 0x10000000, 0x20000000, 0x30000000. Then 1.5 x 1.0 followed by -1.0 x 0.5 -> 0x10000000.
- CE hold: after result 1.0, drive a_in=b_in=0x6000 with ce=0 for 3 cycles -> result stays 0x10000000. Next 0.5 x 1.0 pulse -> 0x18000000.
- Biquad sequence: 0.5 x 1.0, 0.3 x 0.5, 0.2 x 0.2, -0.4 x 0.3, -0.1 x 0.1 -> result ~0.56 (within 5 LSB of Q2.14 rounding error).
- Resets:
  - reset=0 mid-accumulation (after 1.5 x 1.5) -> result 0 asynchronously.
  - mac_rst held two cycles -> result 0; next single accumulate equals its product alone.
- Boundaries:
  - 0x7FFF x 0x4000 -> 0x1FFFC000.
  - 0x8000 x 0x4000 -> 0xE0000000.
  - 0x7FFF x 0x7FFF -> 0x3FFF0001.
  - Repeating the last case 2 more times -> wrapped value, or 0x7FFFFFFF with MAC16_ACC_SAT_EN.

Source files
------------

// File: rtl/mac16_pkg.sv
// Shared widths and fixed-point types for the mac16 accumulate slice.
package mac16_pkg;

  localparam int unsigned A_W      = 16;
  localparam int unsigned B_W      = 16;
  localparam int unsigned ACC_W    = 32;
  localparam int unsigned FRAC_IN  = 14;
  localparam int unsigned FRAC_ACC = 28;

  typedef logic signed [A_W-1:0]   q2_14_t;
  typedef logic signed [ACC_W-1:0] q4_28_t;

endpackage

// File: rtl/mac16_accum_core.sv
// Stage-2 signed multiplier and 32-bit accumulator (Q2.14 x Q2.14 -> Q4.28).
// Define MAC16_ACC_SAT_EN to saturate on signed overflow instead of wrapping.
module mac16_accum_core
  import mac16_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_n,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  q4_28_t prod;
  q4_28_t acc_nxt;

`ifdef MAC16_ACC_SAT_EN
  logic signed [ACC_W:0] sum;

  // One guard bit exposes signed overflow; clamp toward the overflow direction.
  always_comb begin
    prod    = q4_28_t'(a) * q4_28_t'(b);
    sum     = {acc[ACC_W-1], acc} + {prod[ACC_W-1], prod};
    acc_nxt = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    prod    = q4_28_t'(a) * q4_28_t'(b);
    acc_nxt = acc + prod;
  end
`endif

  // Clear has priority over a same-edge accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!clr_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/mac16_wrapper_accum_sim.sv
// Behavioural SB_MAC16 accumulate stand-in: input registers plus accumulator core.
// Optional saturation via MAC16_ACC_SAT_EN (wraps modulo 2^32 when undefined).
module mac16_wrapper_accum_sim
  import mac16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             mac_rst,
  input  logic             ce,
  input  logic [A_W-1:0]   a_in,
  input  logic [B_W-1:0]   b_in,
  output logic [ACC_W-1:0] result
);

  q2_14_t a_reg;
  q2_14_t b_reg;
  logic   ce_reg;
  q4_28_t acc;

  // Operands follow ce only; mac_rst drops the pending accumulate but keeps operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      ce_reg <= 1'b0;
    end else begin
      if (ce) begin
        a_reg <= q2_14_t'(a_in);
        b_reg <= q2_14_t'(b_in);
      end
      ce_reg <= ce & mac_rst;
    end
  end

  mac16_accum_core u_core (
    .clk   (clk),
    .rst_n (reset),
    .clr_n (mac_rst),
    .en    (ce_reg),
    .a     (a_reg),
    .b     (b_reg),
    .acc   (acc)
  );

  assign result = acc;

endmodule

// File: tb/tb_mac16_wrapper_accum_sim.sv
// Self-checking bench for mac16_wrapper_accum_sim against an arithmetic reference model.
module tb_mac16_wrapper_accum_sim;

  logic        clk;
  logic        reset;
  logic        mac_rst;
  logic        ce;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [31:0] result;

  int errors;
  int checks;

  // Reference state: accumulated value and the operand pair still in flight.
  longint m_acc;
  bit     m_pv;
  longint m_pp;

  mac16_wrapper_accum_sim dut (
    .clk     (clk),
    .reset   (reset),
    .mac_rst (mac_rst),
    .ce      (ce),
    .a_in    (a_in),
    .b_in    (b_in),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint fit32(input longint v);
`ifdef MAC16_ACC_SAT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    return longint'(int'(v));
`endif
  endfunction

  function automatic logic [31:0] exp_res();
    return 32'(m_acc);
  endfunction

  // Drive one cycle from a falling edge, advance the model at the rising edge.
  task automatic step(input logic m, input logic c, input logic [15:0] a, input logic [15:0] b);
    mac_rst = m; ce = c; a_in = a; b_in = b;
    @(posedge clk);
    if (!m) m_acc = 0;
    else if (m_pv) m_acc = fit32(m_acc + m_pp);
    m_pv = c && m;
    if (c) m_pp = longint'($signed(a)) * longint'($signed(b));
    @(negedge clk);
  endtask

  task automatic clear_acc();
    step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic pulse(input logic [15:0] a, input logic [15:0] b);
    step(1'b1, 1'b1, a, b);
    step(1'b1, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0; mac_rst = 1'b1; ce = 1'b0; a_in = 16'h0; b_in = 16'h0;
    m_acc = 0; m_pv = 0; m_pp = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_state got=%h want=%h", result, 32'h0);
    end
    reset = 1'b1;
    step(1'b1, 1'b0, 16'h4000, 16'h4000);
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_idle got=%h want=%h", result, 32'h0);
    end
  endtask

  task automatic test_single();
    logic [15:0] av [3] = '{16'h4000, 16'h6000, 16'hC000};
    logic [31:0] ev [3] = '{32'h10000000, 32'h18000000, 32'hF0000000};
    for (int i = 0; i < 3; i++) begin
      clear_acc();
      step(1'b1, 1'b1, av[i], 16'h4000);
      checks++;
      if (result !== 32'h0) begin
        errors++; $display("FAIL single_latency%0d got=%h want=%h", i, result, 32'h0);
      end
      step(1'b1, 1'b0, 16'h0, 16'h0);
      checks++;
      if (result !== ev[i] || result !== exp_res()) begin
        errors++; $display("FAIL single%0d got=%h want=%h", i, result, ev[i]);
      end
    end
  endtask

  task automatic test_accumulate();
    clear_acc();
    for (int i = 1; i <= 3; i++) begin
      pulse(16'h4000, 16'h4000);
      checks++;
      if (result !== 32'(i * 32'h10000000)) begin
        errors++; $display("FAIL accum%0d got=%h want=%h", i, result, 32'(i * 32'h10000000));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_acc();
    step(1'b1, 1'b1, 16'h6000, 16'h4000);
    step(1'b1, 1'b1, 16'hC000, 16'h2000);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    checks++;
    if (result !== 32'h10000000 || result !== exp_res()) begin
      errors++; $display("FAIL back_to_back got=%h want=%h", result, 32'h10000000);
    end
  endtask

  task automatic test_ce_hold();
    clear_acc();
    pulse(16'h4000, 16'h4000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h6000, 16'h6000);
      checks++;
      if (result !== 32'h10000000) begin
        errors++; $display("FAIL ce_hold%0d got=%h want=%h", i, result, 32'h10000000);
      end
    end
    pulse(16'h2000, 16'h4000);
    checks++;
    if (result !== 32'h18000000) begin
      errors++; $display("FAIL ce_hold_next got=%h want=%h", result, 32'h18000000);
    end
  endtask

  task automatic test_biquad();
    real    ca [5] = '{0.5, 0.3, 0.2, -0.4, -0.1};
    real    cb [5] = '{1.0, 0.5, 0.2, 0.3, 0.1};
    longint ideal, diff;
    clear_acc();
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 16'($rtoi(ca[i] * 16384.0 + (ca[i] < 0 ? -0.5 : 0.5))),
                       16'($rtoi(cb[i] * 16384.0 + 0.5)));
    step(1'b1, 1'b0, 16'h0, 16'h0);
    ideal = longint'($rtoi(0.56 * 268435456.0));
    diff  = longint'($signed(result)) - ideal;
    if (diff < 0) diff = -diff;
    checks++;
    if (result !== exp_res()) begin
      errors++; $display("FAIL biquad_model got=%h want=%h", result, exp_res());
    end
    checks++;
    if (diff > 5 * 16384) begin
      errors++; $display("FAIL biquad_tol got=%h want~%h", result, 32'(ideal));
    end
  endtask

  task automatic test_resets();
    clear_acc();
    pulse(16'h6000, 16'h6000);
    checks++;
    if (result !== 32'h24000000) begin
      errors++; $display("FAIL pre_async got=%h want=%h", result, 32'h24000000);
    end
    #2 reset = 1'b0;
    #1;
    m_acc = 0; m_pv = 0; m_pp = 0;
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL async_reset got=%h want=%h", result, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    pulse(16'h4000, 16'h4000);
    pulse(16'h4000, 16'h4000);
    clear_acc();
    clear_acc();
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL mac_rst_hold got=%h want=%h", result, 32'h0);
    end
    pulse(16'h2000, 16'h2000);
    checks++;
    if (result !== 32'h04000000) begin
      errors++; $display("FAIL after_mac_rst got=%h want=%h", result, 32'h04000000);
    end
    step(1'b1, 1'b1, 16'h4000, 16'h4000);
    step(1'b0, 1'b1, 16'h4000, 16'h4000);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    checks++;
    if (result !== 32'h0 || result !== exp_res()) begin
      errors++; $display("FAIL mac_rst_priority got=%h want=%h", result, 32'h0);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] want;
    clear_acc();
    pulse(16'h7FFF, 16'h4000);
    checks++;
    if (result !== 32'h1FFFC000) begin
      errors++; $display("FAIL max_x_one got=%h want=%h", result, 32'h1FFFC000);
    end
    clear_acc();
    pulse(16'h8000, 16'h4000);
    checks++;
    if (result !== 32'hE0000000) begin
      errors++; $display("FAIL min_x_one got=%h want=%h", result, 32'hE0000000);
    end
    clear_acc();
    pulse(16'h7FFF, 16'h7FFF);
    checks++;
    if (result !== 32'h3FFF0001) begin
      errors++; $display("FAIL max_sq got=%h want=%h", result, 32'h3FFF0001);
    end
    pulse(16'h7FFF, 16'h7FFF);
    pulse(16'h7FFF, 16'h7FFF);
`ifdef MAC16_ACC_SAT_EN
    want = 32'h7FFFFFFF;
`else
    want = 32'hBFFD0003;
`endif
    checks++;
    if (result !== want || result !== exp_res()) begin
      errors++; $display("FAIL overflow got=%h want=%h", result, want);
    end
  endtask

  task automatic test_random();
    logic [15:0] ext [4] = '{16'h7FFF, 16'h8000, 16'h8001, 16'h7FFE};
    logic [15:0] a, b;
    clear_acc();
    for (int i = 0; i < 300; i++) begin
      a = ($urandom % 4 == 0) ? ext[$urandom % 4] : 16'($urandom);
      b = ($urandom % 4 == 0) ? ext[$urandom % 4] : 16'($urandom);
      step(($urandom % 12) != 0, 1'($urandom), a, b);
      checks++;
      if (result !== exp_res()) begin
        errors++; $display("FAIL random%0d got=%h want=%h", i, result, exp_res());
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_accumulate();
    test_back_to_back();
    test_ce_hold();
    test_biquad();
    test_resets();
    test_boundaries();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
